// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: default conditioning parameters, the line-pair
// type used by the conditioner and the FSM, and START/STOP decode helpers.
package i2c_pkg;

    localparam int I2C_SYNC_STAGES_DEF = 2;
    localparam int I2C_FILTER_LEN_DEF  = 3;

    typedef struct packed {
        logic scl;
        logic sda;
    } i2c_lines_t;

    localparam i2c_lines_t I2C_LINES_IDLE = '{scl: 1'b1, sda: 1'b1};

    // SDA falling while SCL is high on both the current and previous sample
    function automatic logic i2c_start_cond(input i2c_lines_t cur, input i2c_lines_t prev);
        return cur.scl & prev.scl & prev.sda & ~cur.sda;
    endfunction

    // SDA rising while SCL is high on both the current and previous sample
    function automatic logic i2c_stop_cond(input i2c_lines_t cur, input i2c_lines_t prev);
        return cur.scl & prev.scl & ~prev.sda & cur.sda;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: pad synchroniser chain followed by a hold-time glitch filter.
// The filtered level only follows the synchronised level after it has held.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = I2C_FILTER_LEN_DEF
) (
    input  logic pclk,
    input  logic presetn,
    input  logic enable,
    input  logic line_raw,
    output logic line_filt
);

    localparam int CNT_W    = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int LAST_CNT = (FILTER_LEN > 0) ? (FILTER_LEN - 1) : 0;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST_CNT);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_nxt_s;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain keeps running while disabled so re-enable sees settled data
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_raw};
        end
    end

    // Glitch filter next state: toggle once the level has differed for FILTER_LEN cycles
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = line_filt;
        if (!enable) begin
            cnt_nxt_s   = '0;
            level_nxt_s = 1'b1;
        end else if (FILTER_LEN == 0) begin
            cnt_nxt_s   = '0;
            level_nxt_s = sync_s;
        end else if (sync_s == line_filt) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == LAST_C) begin
            cnt_nxt_s   = '0;
            level_nxt_s = ~line_filt;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Filter state register
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt_r     <= '0;
            line_filt <= 1'b1;
        end else begin
            cnt_r     <= cnt_nxt_s;
            line_filt <= level_nxt_s;
        end
    end

endmodule

// File: rtl/i2c_slave_line_cond.sv
// I2C slave line conditioner: filtered SCL/SDA levels, SCL edge strobes and
// START/STOP/bus-busy indications, all registered, for the slave FSM/datapath.
module i2c_slave_line_cond
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = I2C_FILTER_LEN_DEF
) (
    input  logic pclk,
    input  logic presetn,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    input  logic enable,
    output logic scl_in,
    output logic sda_in,
    output logic rx_edge,
    output logic tx_edge,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    logic       scl_filt_s;
    logic       sda_filt_s;
    i2c_lines_t filt_s;
    i2c_lines_t prev_r;
    logic       rx_edge_s;
    logic       tx_edge_s;
    logic       start_det_s;
    logic       stop_det_s;
    logic       bus_busy_s;

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .pclk      (pclk),
        .presetn   (presetn),
        .enable    (enable),
        .line_raw  (scl_pad_i),
        .line_filt (scl_filt_s)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .pclk      (pclk),
        .presetn   (presetn),
        .enable    (enable),
        .line_raw  (sda_pad_i),
        .line_filt (sda_filt_s)
    );

    assign filt_s = '{scl: scl_filt_s, sda: sda_filt_s};
    assign scl_in = filt_s.scl;
    assign sda_in = filt_s.sda;

    // Edge and bus condition decode; START/STOP need SCL high on both samples
    always_comb begin
        rx_edge_s   = filt_s.scl & ~prev_r.scl;
        tx_edge_s   = ~filt_s.scl & prev_r.scl;
        start_det_s = i2c_start_cond(filt_s, prev_r);
        stop_det_s  = i2c_stop_cond(filt_s, prev_r);
        if (start_det) begin
            bus_busy_s = 1'b1;
        end else if (stop_det) begin
            bus_busy_s = 1'b0;
        end else begin
            bus_busy_s = bus_busy;
        end
    end

    // Strobe, previous-level and busy registers; disable behaves like an idle bus
    always_ff @(posedge pclk) begin
        if (!presetn || !enable) begin
            prev_r    <= I2C_LINES_IDLE;
            rx_edge   <= 1'b0;
            tx_edge   <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            prev_r    <= filt_s;
            rx_edge   <= rx_edge_s;
            tx_edge   <= tx_edge_s;
            start_det <= start_det_s;
            stop_det  <= stop_det_s;
            bus_busy  <= bus_busy_s;
        end
    end

endmodule

// File: doc/i2c_slave_line_cond.md
Name: i2c_slave_line_cond

Overview:
Front-end conditioner for the I2C slave. Synchronises the raw SCL/SDA pad inputs to pclk and removes glitches. Produces the filtered line levels (scl_in, sda_in), the one-cycle SCL edge strobes (rx_edge, tx_edge) and START/STOP/bus-busy indications. All outputs feed i2c_slave_fsm and the shift/counter datapath directly.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line (legal 2..4)
FILTER_LEN, 3, consecutive pclk cycles a synchronised level must hold before the filtered output follows it (0 = filter bypassed)

Ports:
pclk  input  1  system clock
presetn  input  1  synchronous active-low reset, sampled on rising pclk
scl_pad_i  input  1  raw SCL from pad (asynchronous)
sda_pad_i  input  1  raw SDA from pad (asynchronous)
enable  input  1  block enable; 0 forces idle outputs
scl_in  output  1  filtered SCL level
sda_in  output  1  filtered SDA level
rx_edge  output  1  1-cycle pulse, filtered SCL rising edge (sample point)
tx_edge  output  1  1-cycle pulse, filtered SCL falling edge (shift point)
start_det  output  1  1-cycle pulse, START or repeated START
stop_det  output  1  1-cycle pulse, STOP
bus_busy  output  1  high from START until STOP

Behaviour:
- Reset (presetn=0 at a pclk edge): all sync flops=1, filter counters=0, scl_in=1, sda_in=1, the registered prev copies=1, rx_edge/tx_edge/start_det/stop_det=0, bus_busy=0. Reset mid-transfer drops bus_busy immediately. No pulses are generated on the cycle after reset release.
- Sync: each pad passes through a SYNC_STAGES-deep flop chain. The last stage is the filter input.
- Filter, per line, with counter width $clog2(FILTER_LEN+1):
  - Sync input equals filtered level: counter cleared to 0.
  - Input differs: counter increments.
  - Counter reaches FILTER_LEN-1 while the input still differs: filtered level toggles on the next edge and the counter clears.
  - A glitch shorter than FILTER_LEN cycles never reaches the output.
  - FILTER_LEN=0: filtered level = sync output, registered once.
- Edge/condition detect uses registered prev copies scl_p/sda_p of the filtered levels. Outputs are registered one cycle after the filtered change:
  - rx_edge = scl_in & ~scl_p
  - tx_edge = ~scl_in & scl_p
  - start_det = scl_in & scl_p & sda_p & ~sda_in
  - stop_det = scl_in & scl_p & ~sda_p & sda_in
- Simultaneous SCL and SDA change in the same cycle: only the SCL edge strobe fires. No start_det/stop_det, because scl_p and scl_in must both be 1.
- bus_busy:
  - Set on start_det, cleared on stop_det.
  - start_det while busy (repeated START): pulse issued, busy stays 1.
  - stop_det while not busy: pulse issued, busy stays 0.
- Latency, pad change to strobe: SYNC_STAGES + FILTER_LEN + 1 pclk cycles (6 with defaults). Fixed, independent of direction.
- enable=0: sync chain keeps running. Filtered levels forced to 1, counters to 0, strobes to 0, bus_busy cleared. Re-enable while the lines are high causes no spurious strobe.
- At most one of rx_edge/tx_edge is high in any cycle; likewise at most one of start_det/stop_det.

Decomposition:
- Package i2c_pkg:
  - I2C_SYNC_STAGES_DEF=2, I2C_FILTER_LEN_DEF=3
  - typedef struct packed {logic scl; logic sda;} i2c_lines_t, shared by this block and the FSM
- Sub-module i2c_line_filter (sync chain + glitch counter + filtered level for one line), instantiated twice. Edge/START/STOP/busy logic lives in the top.

Test Plan:
- Reset with pads high, release -> scl_in=sda_in=1, no strobes for 20 cycles, bus_busy=0.
- SCL high; SDA 1→0 at cycle 10 -> start_det pulse at cycle 16 (defaults), bus_busy=1 from cycle 17. Then SDA 0→1 with SCL high -> stop_det pulse, bus_busy=0.
- 2-cycle SDA low glitch with SCL high (FILTER_LEN=3) -> sda_in stays 1, no start_det. A 3-cycle low pulse -> start_det fires.
- SCL square wave, period 40 pclk, 8 periods -> exactly 8 rx_edge and 8 tx_edge pulses, each 1 cycle wide, 20 cycles apart.
- SCL and SDA both fall in the same cycle -> tx_edge only, start_det=0. START then a second START before STOP -> two start_det pulses, bus_busy stays 1.
- presetn=0 mid-byte while bus_busy=1 -> next cycle bus_busy=0 and all strobes 0. enable=0 during SCL toggling -> no strobes; re-enable with lines high -> no strobe.
